pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Two-port arbiter that shares the single physical-memory port between the instruction cache and the data cache. It sits between both cache controllers and main memory and grants one full line transaction at a time (read, or write-back). It latches the winner's command, address and write data, and holds them stable on the memory port until `pmem_resp`. It then routes the response back to that requester only.

## Interface
Parameters:
- `ADDR_W`, 16: physical address width (lc3b_word).
- `LINE_W`, 128: cache line width (lc3b_line).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_pmem_read`  in  1  I-cache line-read request; held until `i_pmem_resp`.
- `i_pmem_address`  in  ADDR_W  I-cache line address.
- `i_pmem_resp`  out  1  I-cache completion strobe.
- `i_pmem_rdata`  out  LINE_W  read data to I-cache.
- `d_pmem_read`  in  1  D-cache line-read request.
- `d_pmem_write`  in  1  D-cache write-back request.
- `d_pmem_address`  in  ADDR_W  D-cache line address.
- `d_pmem_wdata`  in  LINE_W  D-cache write-back data.
- `d_pmem_resp`  out  1  D-cache completion strobe.
- `d_pmem_rdata`  out  LINE_W  read data to D-cache.
- `pmem_read`, `pmem_write`  out  1  memory command, registered.
- `pmem_address`  out  ADDR_W  registered.
- `pmem_wdata`  out  LINE_W  registered.
- `pmem_rdata`  in  LINE_W  memory read data.
- `pmem_resp`  in  1  memory completion.
- `owner`  out  2  current grant: 00 none, 01 I, 10 D.

## Operation
- States: `IDLE`, `GRANT_I`, `GRANT_D`.
- In `IDLE`, the arbiter evaluates the live requests: `i_req = i_pmem_read`, `d_req = d_pmem_read | d_pmem_write`.
  - Only one request → that requester wins.
  - Both → the tie-break rule applies (see Configuration).
  - Neither → stay in `IDLE`.
- On a win, at the same edge:
  - Load `pmem_read`, `pmem_write`, `pmem_address` and `pmem_wdata` from the winner.
  - Enter `GRANT_x`.
  - For I: `pmem_write` = 0 and `pmem_wdata` = 0.
- If `d_pmem_read` and `d_pmem_write` are both high, the cycle is a write (write-back has precedence).
- In `GRANT_x`:
  - Command registers hold. Requester inputs are ignored, including deassertion.
  - When `pmem_resp` = 1, `x_pmem_resp` = 1 combinationally in that cycle, and the non-owner's resp stays 0.
  - At the next edge, clear the command registers and return to `IDLE`.
- `i_pmem_rdata` and `d_pmem_rdata` are both driven from `pmem_rdata` unconditionally. Only the resp strobe qualifies the data.
- `pmem_resp` while in `IDLE` is ignored: no resp is forwarded and there is no state change.
- `owner` decodes the state: `IDLE` = 00, `GRANT_I` = 01, `GRANT_D` = 10.

## Timing
- Reset (asynchronous, while `reset_n` = 0):
  - State = `IDLE`.
  - `pmem_read`, `pmem_write` = 0; `pmem_address`, `pmem_wdata` = 0.
  - Both resp outputs = 0; `owner` = 00.
  - Round-robin pointer = I-last, so D wins the first tie.
- Reset asserted mid-grant aborts the transaction; no resp is forwarded.
- Grant latency:
  - A request seen in `IDLE` at edge N → `pmem_*` valid after edge N.
  - There is one cycle of arbitration overhead per transaction.
- Resp path: `pmem_resp` to `x_pmem_resp` is zero-cycle (combinational).
- After a resp there is at least one `IDLE` cycle. The cache controller's next request, e.g. a D readin following a writeback, is arbitrated fresh in that cycle.
- Back-to-back ownership by the same requester is allowed.
- Requests arriving during a grant wait; no request is lost, because the caches hold their requests.

## Configuration
- Macro: `PMEM_ARB_ROUND_ROBIN_EN`.
- Defined:
  - On a tie, the requester that did not win the last grant wins.
  - A 1-bit `last_grant` register updates on every grant.
- Undefined:
  - Fixed priority, D over I.
  - `last_grant` is not implemented.

## Structure
- Shared package `lc3b_types` holds:
  - `lc3b_word` and `lc3b_line`.
  - An `arb_owner_t` enum {`ARB_NONE`, `ARB_I`, `ARB_D`}, used for `owner` and as the state encoding.
- Sub-module `pmem_cmd_reg` holds the latched command. It has load and clear controls and covers `read`, `write`, `address` and `wdata`.

## Test plan
- I-only read to 0x1230 while memory responds after 3 cycles:
  - `pmem_read` = 1 and `pmem_address` = 0x1230 starting the cycle after the request.
  - `i_pmem_resp` pulses once with `pmem_rdata`; `d_pmem_resp` stays 0.
- Simultaneous I read 0x0040 and D read 0x8000:
  - Fixed priority: D is granted first, then I after D's resp plus one `IDLE` cycle.
  - With the macro defined: D first, then I, then D on the next tie.
- D dirty miss: write-back to 0x2000 with wdata 0xDEAD…BEEF, then read 0x3000, while I requests continuously:
  - Fixed priority: write, then D read.
  - With the macro defined: write, I read, D read.
- I request deasserts, or its address changes, mid-grant:
  - `pmem_address` and `pmem_read` stay at the latched values until `pmem_resp`.
- Spurious `pmem_resp` in `IDLE`:
  - No resp is forwarded; state stays `IDLE`.
- `reset_n` pulsed low during `GRANT_D`:
  - All outputs go to 0 immediately.
  - After release, the pending I request is granted normally.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared LC-3b memory-side types: word/line typedefs and the arbiter owner/state encoding.
package lc3b_types;
  localparam int LC3B_WORD_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  // Doubles as the arbiter state encoding, so owner is just the state register.
  typedef enum logic [1:0] {
    ARB_NONE = 2'b00,
    ARB_I    = 2'b01,
    ARB_D    = 2'b10
  } arb_owner_t;
endpackage

// File: rtl/pmem_arbiter_if.sv
// Bus bundle between I-cache, D-cache, the arbiter and physical memory.
interface pmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic              i_pmem_resp;
    logic [LINE_W-1:0] i_pmem_rdata;

    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic              d_pmem_resp;
    logic [LINE_W-1:0] d_pmem_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter side.
    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_resp, i_pmem_rdata,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_resp, d_pmem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Caches plus memory side.
    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_resp, i_pmem_rdata,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_resp, d_pmem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_arbiter_cmd_reg.sv
// Latched memory command (read/write/address/wdata) held stable for a whole line transaction.
module pmem_cmd_reg #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              o_read,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_address,
    output logic [LINE_W-1:0] o_wdata
);
    logic              r_read;
    logic              r_write;
    logic [ADDR_W-1:0] r_address;
    logic [LINE_W-1:0] r_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
        end else if (i_clear) begin
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
        end else if (i_load) begin
            r_read    <= i_read;
            r_write   <= i_write;
            r_address <= i_address;
            r_wdata   <= i_wdata;
        end
    end

    assign o_read    = r_read;
    assign o_write   = r_write;
    assign o_address = r_address;
    assign o_wdata   = r_wdata;
endmodule

// File: rtl/pmem_arbiter.sv
// I-cache / D-cache arbiter for the single physical-memory port, one line transaction at a time.
// Tie-break: fixed D-over-I by default; PMEM_ARB_ROUND_ROBIN_EN selects alternating priority.
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic          clk,
    input  logic          reset_n,
    pmem_arbiter_if.slave bus,
    output arb_owner_t    owner
);
    arb_owner_t        r_state;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_pick_d;
    logic              w_load;
    logic              w_clear;
    logic              w_ld_read;
    logic              w_ld_write;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [LINE_W-1:0] w_ld_wdata;

    assign w_i_req = bus.i_pmem_read;
    assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;
    // On a tie, D wins only if I took the previous grant.
    assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
`else
    assign w_pick_d = w_d_req;
`endif

    assign w_load  = (r_state == ARB_NONE) & (w_i_req | w_d_req);
    assign w_clear = (r_state != ARB_NONE) & bus.pmem_resp;

    // Write-back takes precedence when the D-cache raises both strobes.
    assign w_ld_read  = w_pick_d ? (bus.d_pmem_read & ~bus.d_pmem_write) : 1'b1;
    assign w_ld_write = w_pick_d & bus.d_pmem_write;
    assign w_ld_addr  = w_pick_d ? bus.d_pmem_address : bus.i_pmem_address;
    assign w_ld_wdata = w_pick_d ? bus.d_pmem_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_NONE;
        end else begin
            case (r_state)
                ARB_NONE: if (w_load) r_state <= w_pick_d ? ARB_D : ARB_I;
                ARB_I,
                ARB_D:    if (bus.pmem_resp) r_state <= ARB_NONE;
                default:  r_state <= ARB_NONE;
            endcase
        end
    end

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_last_d <= 1'b0;
        else if (w_load) r_last_d <= w_pick_d;
    end
`endif

    pmem_cmd_reg #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) u_cmd (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_load),
        .i_clear  (w_clear),
        .i_read   (w_ld_read),
        .i_write  (w_ld_write),
        .i_address(w_ld_addr),
        .i_wdata  (w_ld_wdata),
        .o_read   (bus.pmem_read),
        .o_write  (bus.pmem_write),
        .o_address(bus.pmem_address),
        .o_wdata  (bus.pmem_wdata)
    );

    assign owner           = r_state;
    assign bus.i_pmem_resp = bus.pmem_resp & (r_state == ARB_I);
    assign bus.d_pmem_resp = bus.pmem_resp & (r_state == ARB_D);
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_pmem_arbiter.sv
// Cycle-by-cycle vector bench for pmem_arbiter plus a reset-during-grant sequence.
module tb_pmem_arbiter;
    import lc3b_types::*;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [127:0] WD  = 128'hDEAD_0123_4567_89AB_CDEF_0123_4567_BEEF;
    localparam logic [127:0] RD1 = 128'hA5A5_5A5A_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] RD2 = 128'h0F0F_F0F0_1234_5678_9ABC_DEF0_CAFE_F00D;
    localparam logic [127:0] RD3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] Z   = 128'h0;

    logic       clk;
    logic       reset_n;
    arb_owner_t owner;
    int         n_chk;
    int         n_err;

    pmem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         ir;
        logic [15:0]  ia;
        logic         dr;
        logic         dw;
        logic [15:0]  da;
        logic [127:0] dwd;
        logic         ps;
        logic [127:0] prd;
        logic         e_pr;
        logic         e_pw;
        logic [15:0]  e_pa;
        logic [127:0] e_pwd;
        logic         e_ir;
        logic         e_dr;
        logic [1:0]   e_own;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string n, input logic ir, input logic [15:0] ia,
                                input logic dr, input logic dw, input logic [15:0] da,
                                input logic [127:0] dwd, input logic ps, input logic [127:0] prd,
                                input logic epr, input logic epw, input logic [15:0] epa,
                                input logic [127:0] epwd, input logic eir, input logic edr,
                                input logic [1:0] eo);
        vec_t v;
        v.name = n; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.ps = ps; v.prd = prd; v.e_pr = epr; v.e_pw = epw; v.e_pa = epa; v.e_pwd = epwd;
        v.e_ir = eir; v.e_dr = edr; v.e_own = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                         input logic [15:0] da, input logic [127:0] dwd, input logic ps,
                         input logic [127:0] prd);
        bus.i_pmem_read    = ir;
        bus.i_pmem_address = ia;
        bus.d_pmem_read    = dr;
        bus.d_pmem_write   = dw;
        bus.d_pmem_address = da;
        bus.d_pmem_wdata   = dwd;
        bus.pmem_resp      = ps;
        bus.pmem_rdata     = prd;
    endtask

    task automatic check_all(input string nm, input int row, input logic epr, input logic epw,
                             input logic [15:0] epa, input logic [127:0] epwd, input logic eir,
                             input logic edr, input logic [1:0] eo, input logic [127:0] prd);
        chk({nm, ".pmem_read"},    row, 128'(bus.pmem_read),    128'(epr));
        chk({nm, ".pmem_write"},   row, 128'(bus.pmem_write),   128'(epw));
        chk({nm, ".pmem_address"}, row, 128'(bus.pmem_address), 128'(epa));
        chk({nm, ".pmem_wdata"},   row, bus.pmem_wdata,         epwd);
        chk({nm, ".i_resp"},       row, 128'(bus.i_pmem_resp),  128'(eir));
        chk({nm, ".d_resp"},       row, 128'(bus.d_pmem_resp),  128'(edr));
        chk({nm, ".owner"},        row, 128'(owner),            128'(eo));
        chk({nm, ".i_rdata"},      row, bus.i_pmem_rdata,       prd);
        chk({nm, ".d_rdata"},      row, bus.d_pmem_rdata,       prd);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // name, ir ia, dr dw da dwd, ps prd | e_pr e_pw e_pa e_pwd e_ir e_dr e_own
        vq.push_back(mk("reset",   0, 16'h0000, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("i_req",   1, 16'h1230, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("i_gnt1",  1, 16'h1230, 0, 0, 16'h0000, Z,  0, Z,   1, 0, 16'h1230, Z, 0, 0, 2'b01));
        vq.push_back(mk("i_gnt2",  1, 16'h1230, 0, 0, 16'h0000, Z,  0, Z,   1, 0, 16'h1230, Z, 0, 0, 2'b01));
        vq.push_back(mk("i_resp",  1, 16'h1230, 0, 0, 16'h0000, Z,  1, RD1, 1, 0, 16'h1230, Z, 1, 0, 2'b01));
        vq.push_back(mk("i_idle",  0, 16'h0000, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("tie_req", 1, 16'h0040, 1, 0, 16'h8000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("tie_d",   1, 16'h0040, 1, 0, 16'h8000, Z,  0, Z,   1, 0, 16'h8000, Z, 0, 0, 2'b10));
        vq.push_back(mk("tie_dr",  1, 16'h0040, 1, 0, 16'h8000, Z,  1, RD2, 1, 0, 16'h8000, Z, 0, 1, 2'b10));
        vq.push_back(mk("tie_gap", 1, 16'h0040, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("tie_i",   1, 16'h0040, 0, 0, 16'h0000, Z,  0, Z,   1, 0, 16'h0040, Z, 0, 0, 2'b01));
        vq.push_back(mk("tie_ir",  1, 16'h0040, 0, 0, 16'h0000, Z,  1, RD3, 1, 0, 16'h0040, Z, 1, 0, 2'b01));
        vq.push_back(mk("wb_req",  1, 16'h0040, 1, 1, 16'h2000, WD, 0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("wb_gnt",  1, 16'h0040, 1, 1, 16'h2000, WD, 0, Z,   0, 1, 16'h2000, WD, 0, 0, 2'b10));
        vq.push_back(mk("wb_resp", 1, 16'h0040, 1, 1, 16'h2000, WD, 1, RD1, 0, 1, 16'h2000, WD, 0, 1, 2'b10));
        vq.push_back(mk("rd_req",  1, 16'h0040, 1, 0, 16'h3000, WD, 0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("rd_gnt",  1, 16'h0040, 1, 0, 16'h3000, WD, 0, Z,
                        1, 0, RR ? 16'h0040 : 16'h3000, RR ? Z : WD, 0, 0, RR ? 2'b01 : 2'b10));
        vq.push_back(mk("rd_resp", 1, 16'h0040, 1, 0, 16'h3000, WD, 1, RD2,
                        1, 0, RR ? 16'h0040 : 16'h3000, RR ? Z : WD, RR, !RR, RR ? 2'b01 : 2'b10));
        vq.push_back(mk("rd2_req", 1, 16'h0040, RR, 0, 16'h3000, WD, 0, Z,  0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("rd2_gnt", 1, 16'h0040, RR, 0, 16'h3000, WD, 0, Z,
                        1, 0, RR ? 16'h3000 : 16'h0040, RR ? WD : Z, 0, 0, RR ? 2'b10 : 2'b01));
        vq.push_back(mk("rd2_rsp", 1, 16'h0040, RR, 0, 16'h3000, WD, 1, RD3,
                        1, 0, RR ? 16'h3000 : 16'h0040, RR ? WD : Z, !RR, RR, RR ? 2'b10 : 2'b01));
        vq.push_back(mk("rd_idle", 0, 16'h0000, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("hold_rq", 1, 16'h0100, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("hold_ad", 1, 16'h0FFF, 0, 0, 16'h0000, Z,  0, Z,   1, 0, 16'h0100, Z, 0, 0, 2'b01));
        vq.push_back(mk("hold_dn", 0, 16'h0FFF, 0, 0, 16'h0000, Z,  0, Z,   1, 0, 16'h0100, Z, 0, 0, 2'b01));
        vq.push_back(mk("hold_rs", 0, 16'h0FFF, 0, 0, 16'h0000, Z,  1, RD1, 1, 0, 16'h0100, Z, 1, 0, 2'b01));
        vq.push_back(mk("hold_id", 0, 16'h0000, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("spur_rs", 0, 16'h0000, 0, 0, 16'h0000, Z,  1, RD2, 0, 0, 16'h0000, Z, 0, 0, 2'b00));
        vq.push_back(mk("spur_id", 0, 16'h0000, 0, 0, 16'h0000, Z,  0, Z,   0, 0, 16'h0000, Z, 0, 0, 2'b00));

        reset_n = 1'b0;
        drive(0, 16'h0, 0, 0, 16'h0, Z, 0, Z);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int r = 0; r < vq.size(); r++) begin
            @(negedge clk);
            drive(vq[r].ir, vq[r].ia, vq[r].dr, vq[r].dw, vq[r].da, vq[r].dwd, vq[r].ps, vq[r].prd);
            #1;
            check_all(vq[r].name, r, vq[r].e_pr, vq[r].e_pw, vq[r].e_pa, vq[r].e_pwd,
                      vq[r].e_ir, vq[r].e_dr, vq[r].e_own, vq[r].prd);
        end

        // Reset pulsed during a D grant, with an I request waiting behind it.
        @(negedge clk);
        drive(0, 16'h0000, 1, 0, 16'h8000, WD, 0, Z);
        @(negedge clk);
        drive(1, 16'h0040, 1, 0, 16'h8000, WD, 0, Z);
        #1;
        check_all("rst_gnt", 100, 1, 0, 16'h8000, WD, 0, 0, 2'b10, Z);
        #1;
        reset_n = 1'b0;
        drive(1, 16'h0040, 1, 0, 16'h8000, WD, 1, RD1);
        #1;
        check_all("rst_abort", 101, 0, 0, 16'h0000, Z, 0, 0, 2'b00, RD1);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 16'h0040, 0, 0, 16'h0000, Z, 0, Z);
        #1;
        check_all("rst_rel", 102, 0, 0, 16'h0000, Z, 0, 0, 2'b00, Z);
        @(negedge clk);
        #1;
        check_all("rst_igt", 103, 1, 0, 16'h0040, Z, 0, 0, 2'b01, Z);
        @(negedge clk);
        drive(1, 16'h0040, 0, 0, 16'h0000, Z, 1, RD3);
        #1;
        check_all("rst_irs", 104, 1, 0, 16'h0040, Z, 1, 0, 2'b01, RD3);
        @(negedge clk);
        drive(0, 16'h0000, 0, 0, 16'h0000, Z, 0, Z);
        #1;
        check_all("rst_end", 105, 0, 0, 16'h0000, Z, 0, 0, 2'b00, Z);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
